// File: rtl/lcd_hd44780_ctrl.sv
// lcd_hd44780_ctrl
// Memory-mapped HD44780 character-LCD controller. Stores written through the
// QUEUE register are buffered as {RS, byte} entries in a small FIFO. A
// sequencer turns each entry into one timed bus transfer made of four phases:
// setup, E pulse, hold and execute-wait. The CTRL register controls panel
// power, clears the sticky overflow flag and flushes the FIFO. A status word
// lets firmware poll the controller instead of busy-waiting.

module lcd_hd44780_ctrl #(
   parameter int FIFO_DEPTH = 4,      // power of 2, >= 2
   parameter int SETUP_CYC  = 4,      // RS/DATA stable before E rises
   parameter int PULSE_CYC  = 12,     // E high time
   parameter int HOLD_CYC   = 4,      // RS/DATA held after E falls
   parameter int EXEC_CYC   = 2000,   // execute wait, normal command/data
   parameter int CLR_CYC    = 82000   // execute wait, Clear/Home
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        st_en,
   input  logic        st_addr,
   input  logic [31:0] st_data,
   output logic [31:0] status_o,
   output logic [7:0]  lcd_data_o,
   output logic        lcd_rs_o,
   output logic        lcd_rw_o,
   output logic        lcd_en_o,
   output logic        lcd_on_o,
   output logic [11:0] o_io_lcd
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int PH_W  = $clog2(CLR_CYC + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_SETUP,
      S_PULSE,
      S_HOLD,
      S_WAIT
   } state_e;

   // ---------------------------------------------------------------------
   // Store decode
   // ---------------------------------------------------------------------
   logic queue_wr;
   logic ctrl_wr;
   logic flush;
   logic push;
   logic pop;
   logic full;
   logic empty;

   // Only the RS bit and the data byte of a store are meaningful.
   logic unused_st_data;
   assign unused_st_data = ^st_data[31:9];

   // ---------------------------------------------------------------------
   // Command FIFO
   // ---------------------------------------------------------------------
   logic [8:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             ovf_q, ovf_d;
   logic             on_q, on_d;
   logic [8:0]       head;

   // ---------------------------------------------------------------------
   // Sequencer
   // ---------------------------------------------------------------------
   state_e           state_q, state_d;
   logic [PH_W-1:0]  ph_cnt_q, ph_cnt_d;
   logic             rs_q, rs_d;
   logic [7:0]       data_q, data_d;
   logic             is_long_cmd;
   logic             busy;

   assign queue_wr = st_en & ~st_addr;
   assign ctrl_wr  = st_en & st_addr;
   assign flush    = ctrl_wr & st_data[2];

   // full is taken from the registered count, so a pop in the same cycle
   // never makes room for a push that arrives while the FIFO is full.
   assign full  = (count_q == CNT_W'(FIFO_DEPTH));
   assign empty = (count_q == '0);
   assign push  = queue_wr & ~full;

   // A flush in the same cycle suppresses the pop, so a flushed entry is
   // never started.
   assign pop   = (state_q == S_IDLE) & ~empty & ~flush;

   assign head  = fifo_mem[rd_ptr_q];

   // Clear (0x01) and Home (0x02) need the long execute time.
   assign is_long_cmd = ~rs_q & ((data_q == 8'h01) | (data_q == 8'h02));

   // Entry storage: write the pushed {RS, byte} at the write pointer.
   // NOTE: the storage array has no reset; count gates every read, so stale
   // contents are never observed and the array can map onto plain flops/RAM.
   always_ff @(posedge clk_i) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= {st_data[8], st_data[7:0]};
      end
   end

   // FIFO bookkeeping and CTRL register next-state.
   // NOTE: every variable gets a default at the top of a combinational block,
   // otherwise paths that skip an assignment would infer latches.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      ovf_d    = ovf_q;
      on_d     = on_q;

      if (flush) begin
         // Discard queued entries; the transfer in flight is untouched.
         rd_ptr_d = wr_ptr_q;
         count_d  = '0;
      end else begin
         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end

      if (queue_wr && full) begin
         ovf_d = 1'b1;
      end
      if (ctrl_wr) begin
         on_d = st_data[0];
         if (st_data[1]) begin
            ovf_d = 1'b0;
         end
      end
   end

   // FIFO and CTRL state registers.
   // NOTE: sequential state is always assigned with non-blocking <= so every
   // flop samples the values from before the clock edge.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
         on_q     <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ovf_q    <= ovf_d;
         on_q     <= on_d;
      end
   end

   // Sequencer state register: phase, phase counter and latched entry.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q  <= S_IDLE;
         ph_cnt_q <= '0;
         rs_q     <= 1'b0;
         data_q   <= 8'h00;
      end else begin
         state_q  <= state_d;
         ph_cnt_q <= ph_cnt_d;
         rs_q     <= rs_d;
         data_q   <= data_d;
      end
   end

   // Sequencer next-state: each phase loads N-1 on entry and advances at 0.
   always_comb begin
      state_d  = state_q;
      ph_cnt_d = ph_cnt_q;
      rs_d     = rs_q;
      data_d   = data_q;

      unique case (state_q)
         S_IDLE: begin
            if (pop) begin
               state_d  = S_SETUP;
               ph_cnt_d = PH_W'(SETUP_CYC - 1);
               rs_d     = head[8];
               data_d   = head[7:0];
            end
         end
         S_SETUP: begin
            if (ph_cnt_q == '0) begin
               state_d  = S_PULSE;
               ph_cnt_d = PH_W'(PULSE_CYC - 1);
            end else begin
               ph_cnt_d = ph_cnt_q - 1'b1;
            end
         end
         S_PULSE: begin
            if (ph_cnt_q == '0) begin
               state_d  = S_HOLD;
               ph_cnt_d = PH_W'(HOLD_CYC - 1);
            end else begin
               ph_cnt_d = ph_cnt_q - 1'b1;
            end
         end
         S_HOLD: begin
            if (ph_cnt_q == '0) begin
               state_d  = S_WAIT;
               ph_cnt_d = is_long_cmd ? PH_W'(CLR_CYC - 1) : PH_W'(EXEC_CYC - 1);
            end else begin
               ph_cnt_d = ph_cnt_q - 1'b1;
            end
         end
         S_WAIT: begin
            if (ph_cnt_q == '0) begin
               state_d = S_IDLE;
            end else begin
               ph_cnt_d = ph_cnt_q - 1'b1;
            end
         end
         default: begin
            state_d  = S_IDLE;
            ph_cnt_d = '0;
         end
      endcase
   end

   // Outputs: E is decoded straight from the state register, so a reset
   // drops it in the same cycle; the rest comes from registers.
   always_comb begin
      busy       = (state_q != S_IDLE) | ~empty;
      lcd_en_o   = (state_q == S_PULSE);
      lcd_rs_o   = rs_q;
      lcd_data_o = data_q;
      lcd_rw_o   = 1'b0;
      lcd_on_o   = on_q;
      o_io_lcd   = {on_q, lcd_en_o, 1'b0, rs_q, data_q};
      status_o   = {16'h0000, 8'(count_q), 4'h0, ovf_q, full, busy, on_q};
   end

endmodule

// File: tb/tb_lcd_hd44780_ctrl.sv
// tb_lcd_hd44780_ctrl
// Directed bench for lcd_hd44780_ctrl with short phase timings:
// SETUP=2 PULSE=3 HOLD=2 EXEC=10 CLR=40 DEPTH=4.
// Inputs change and outputs are sampled 1 ns after each rising edge.

module tb_lcd_hd44780_ctrl;

   logic        clk;
   logic        rst_n;
   logic        st_en;
   logic        st_addr;
   logic [31:0] st_data;
   logic [31:0] status;
   logic [7:0]  lcd_data;
   logic        lcd_rs;
   logic        lcd_rw;
   logic        lcd_en;
   logic        lcd_on;
   logic [11:0] io_lcd;

   int n_tests = 0;
   int n_fail  = 0;

   lcd_hd44780_ctrl #(
      .FIFO_DEPTH (4),
      .SETUP_CYC  (2),
      .PULSE_CYC  (3),
      .HOLD_CYC   (2),
      .EXEC_CYC   (10),
      .CLR_CYC    (40)
   ) dut (
      .clk_i      (clk),
      .rst_ni     (rst_n),
      .st_en      (st_en),
      .st_addr    (st_addr),
      .st_data    (st_data),
      .status_o   (status),
      .lcd_data_o (lcd_data),
      .lcd_rs_o   (lcd_rs),
      .lcd_rw_o   (lcd_rw),
      .lcd_en_o   (lcd_en),
      .lcd_on_o   (lcd_on),
      .o_io_lcd   (io_lcd)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One store, sampled by the next rising edge; returns 1 ns after it.
   task automatic store(input logic addr, input logic [31:0] data);
      st_en   = 1'b1;
      st_addr = addr;
      st_data = data;
      tick(1);
      st_en   = 1'b0;
      st_data = 32'h0;
   endtask

   // Push one entry with the FSM idle and time every phase of its transfer.
   task automatic send_and_time(input logic [31:0] d, input int wait_cyc, input string tag);
      store(1'b0, d);                                         // edge t
      check(status, 32'h0000_0102, {tag, "_queued"});
      tick(1);                                                // t+1
      check({23'h0, lcd_rs, lcd_data}, {23'h0, d[8:0]}, {tag, "_latched"});
      check({31'h0, lcd_en}, 32'h0, {tag, "_en_setup"});
      tick(1);                                                // t+2
      check({31'h0, lcd_en}, 32'h0, {tag, "_en_before_rise"});
      tick(1);                                                // t+3
      check({20'h0, io_lcd}, {20'h0, 1'b0, 1'b1, 1'b0, d[8], d[7:0]}, {tag, "_io_pulse"});
      tick(2);                                                // t+5
      check({31'h0, lcd_en}, 32'h1, {tag, "_en_last_high"});
      tick(1);                                                // t+6
      check({31'h0, lcd_en}, 32'h0, {tag, "_en_fall"});
      tick(1 + wait_cyc);                                     // t+7+wait
      check(status, 32'h0000_0002, {tag, "_busy_end_wait"});
      tick(1);                                                // t+8+wait
      check(status, 32'h0000_0000, {tag, "_idle"});
   endtask

   initial begin
      logic [7:0] got [$];
      logic       prev_en;
      int         rises;

      rst_n   = 1'b0;
      st_en   = 1'b0;
      st_addr = 1'b0;
      st_data = 32'h0;
      tick(3);
      check(status, 32'h0, "reset_status");
      check({20'h0, io_lcd}, 32'h0, "reset_io");
      rst_n = 1'b1;
      tick(2);
      check(status, 32'h0, "idle_status");

      // Single transfers: data, Clear/Home (long wait), normal command,
      // and RS=1 with byte 0x01, which must use the short wait.
      send_and_time(32'h141, 10, "data_A");
      send_and_time(32'h001, 40, "clear");
      send_and_time(32'h002, 40, "home");
      send_and_time(32'h080, 10, "ddram");
      send_and_time(32'h101, 10, "rs1_byte01");

      // Six back-to-back pushes: first popped, four queued, sixth dropped.
      for (int i = 0; i < 6; i++) begin
         store(1'b0, 32'h131 + i);
      end
      check(status, 32'h0000_040E, "burst_full_ovf");
      check({31'h0, lcd_en}, 32'h1, "burst_first_pulse");
      got.push_back(lcd_data);
      prev_en = lcd_en;
      for (int c = 0; c < 200 && status[1]; c++) begin
         tick(1);
         if (lcd_en && !prev_en) got.push_back(lcd_data);
         prev_en = lcd_en;
      end
      check(status, 32'h0000_0008, "burst_done_ovf_kept");
      check(got.size(), 5, "burst_count");
      for (int i = 0; i < 5; i++) begin
         check({24'h0, (i < got.size()) ? got[i] : 8'hxx}, 32'h31 + i, $sformatf("burst_order_%0d", i));
      end

      store(1'b1, 32'h2);
      check(status, 32'h0, "ovf_clear");

      // Flush while the first entry's E pulse is in progress.
      store(1'b0, 32'h150);                                   // t
      store(1'b0, 32'h151);                                   // t+1
      store(1'b0, 32'h152);                                   // t+2
      tick(1);                                                // t+3
      check({31'h0, lcd_en}, 32'h1, "flush_pulse_start");
      store(1'b1, 32'h4);                                     // t+4
      check(status, 32'h0000_0002, "flush_count0");
      tick(1);                                                // t+5
      check({31'h0, lcd_en}, 32'h1, "flush_pulse_kept");
      tick(1);                                                // t+6
      check({31'h0, lcd_en}, 32'h0, "flush_pulse_end");
      rises   = 0;
      prev_en = lcd_en;
      for (int c = 0; c < 80; c++) begin
         tick(1);
         if (lcd_en && !prev_en) rises++;
         prev_en = lcd_en;
      end
      check(rises, 0, "flush_no_more_pulses");
      check(status, 32'h0, "flush_idle");
      check({24'h0, lcd_data}, 32'h50, "flush_last_data");

      // Panel power does not disturb queued entries.
      store(1'b1, 32'h1);
      check({31'h0, lcd_on}, 32'h1, "on_pin");
      check({31'h0, io_lcd[11]}, 32'h1, "on_io_bit");
      store(1'b0, 32'h160);                                   // t
      store(1'b0, 32'h161);                                   // t+1, first popped
      store(1'b1, 32'h0);                                     // t+2
      check({31'h0, lcd_on}, 32'h0, "off_pin");
      check(status, 32'h0000_0102, "off_fifo_kept");
      for (int c = 0; c < 100 && status[1]; c++) tick(1);
      check(status, 32'h0, "off_drained");
      check({24'h0, lcd_data}, 32'h61, "off_last_data");

      // Reset in the middle of an E pulse.
      store(1'b1, 32'h1);
      store(1'b0, 32'h141);                                   // t
      store(1'b0, 32'h142);                                   // t+1
      tick(2);                                                // t+3
      check({31'h0, lcd_en}, 32'h1, "rst_pre_pulse");
      check(status, 32'h0000_0103, "rst_pre_status");
      rst_n = 1'b0;
      #1;
      check({31'h0, lcd_en}, 32'h0, "rst_en_drop");
      check(status, 32'h0, "rst_status");
      check({20'h0, io_lcd}, 32'h0, "rst_io");
      tick(2);
      rst_n = 1'b1;
      rises   = 0;
      prev_en = lcd_en;
      for (int c = 0; c < 20; c++) begin
         tick(1);
         if (lcd_en && !prev_en) rises++;
         prev_en = lcd_en;
      end
      check(rises, 0, "rst_no_resume");
      check(status, 32'h0, "rst_after_release");

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
